// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/decode front end.
// The IF/ID struct carries a full 32-bit pc field; users keep only their low PC_W bits.
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam int          PC_MAX_W  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic                valid;
        logic [PC_MAX_W-1:0] pc;
        logic [XLEN-1:0]     instr;
    } ifid_t;

    // Empty pipeline slot: what reset and a redirect flush leave behind.
    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

endpackage

// File: rtl/regfile_bypass.sv
// Register file with asynchronous clear, synchronous write and write-to-read bypass.
// Index 0 and indices beyond NREGS always read as zero and are never written.
module regfile_bypass
    import fetch_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  reg_idx_t        wr_dest,
    input  logic [XLEN-1:0] wr_data,
    input  reg_idx_t        rd_idx1,
    input  reg_idx_t        rd_idx2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_ok;

    assign wr_ok = wr_en && (wr_dest != '0) && (32'(wr_dest) < 32'(NREGS));

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (32'(wr_dest) == 32'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    // Zero-index / out-of-range test comes last so it wins over the bypass.
    always_comb begin
        rd_data1 = regs_q[rd_idx1[IW-1:0]];
        if (wr_en && (wr_dest == rd_idx1)) rd_data1 = wr_data;
        if ((rd_idx1 == '0) || (32'(rd_idx1) >= 32'(NREGS))) rd_data1 = '0;

        rd_data2 = regs_q[rd_idx2[IW-1:0]];
        if (wr_en && (wr_dest == rd_idx2)) rd_data2 = wr_data;
        if ((rd_idx2 == '0) || (32'(rd_idx2) >= 32'(NREGS))) rd_data2 = '0;
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch stage (PC, instruction memory) plus IF/ID register and decode-stage register reads.
// Instruction memory is loaded through the write port and survives reset.
module fetch_decode_unit
    import fetch_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int IMEM_WORDS = 64,
    parameter int RESET_PC   = 0,
    parameter int NREGS      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            imem_we,
    input  logic [PC_W-1:0] imem_waddr,
    input  logic [31:0]     imem_wdata,
    input  logic            rg_wrt_en,
    input  logic [4:0]      rg_wrt_dest,
    input  logic [31:0]     rg_wrt_data,
    output logic [PC_W-1:0] pc_out,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [31:0]     rg_rd_data1,
    output logic [31:0]     rg_rd_data2
);

    localparam int WIDX_W = PC_W - 2;
    localparam int AW     = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    logic [PC_W-1:0]   pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic [XLEN-1:0]   imem [IMEM_WORDS];
    logic [WIDX_W-1:0] fetch_idx, wr_idx;
    logic              fetch_hit, wr_hit;
    logic [XLEN-1:0]   fetch_word;

    assign fetch_idx  = pc_q[PC_W-1:2];
    assign wr_idx     = imem_waddr[PC_W-1:2];
    assign fetch_hit  = 32'(fetch_idx) < 32'(IMEM_WORDS);
    assign wr_hit     = 32'(wr_idx) < 32'(IMEM_WORDS);
    assign fetch_word = fetch_hit ? imem[fetch_idx[AW-1:0]] : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (imem_we && wr_hit) begin
            imem[wr_idx[AW-1:0]] <= imem_wdata;
        end
    end

    // Redirect outranks stall: a redirect always flushes, even in a stalled cycle.
    always_comb begin
        pc_d   = pc_q + PC_W'(4);
        ifid_d = ifid_q;
        if (redirect_en) begin
            pc_d   = {redirect_pc[PC_W-1:2], 2'b00};
            ifid_d = IFID_BUBBLE;
        end else if (stall) begin
            pc_d   = pc_q;
        end else begin
            ifid_d.valid = 1'b1;
            ifid_d.pc    = PC_MAX_W'(pc_q);
            ifid_d.instr = fetch_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= PC_W'(RESET_PC);
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign pc_out   = pc_q;
    assign id_valid = ifid_q.valid;
    assign id_pc    = ifid_q.pc[PC_W-1:0];
    assign id_instr = ifid_q.instr;

    regfile_bypass #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (reset),
        .wr_en    (rg_wrt_en),
        .wr_dest  (rg_wrt_dest),
        .wr_data  (rg_wrt_data),
        .rd_idx1  (ifid_q.instr[19:15]),
        .rd_idx2  (ifid_q.instr[24:20]),
        .rd_data1 (rg_rd_data1),
        .rd_data2 (rg_rd_data2)
    );

    // Byte-offset bits and the spare high pc bits of the IF/ID struct carry no information.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{redirect_pc[1:0], imem_waddr[1:0]};

    generate
        if (PC_W < PC_MAX_W) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = |ifid_q.pc[PC_MAX_W-1:PC_W];
        end
    endgenerate

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: a cycle-level reference model checked every
// falling edge, plus hand-computed literal expectations at the scenario points.
module tb_fetch_decode_unit;

    localparam int          PC_W       = 8;
    localparam int          IMEM_WORDS = 32;
    localparam int          NREGS      = 32;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        rg_wrt_en = 1'b0;
    logic [4:0]  rg_wrt_dest = '0;
    logic [31:0] rg_wrt_data = '0;
    logic [7:0]  pc_out;
    logic        id_valid;
    logic [7:0]  id_pc;
    logic [31:0] id_instr;
    logic [31:0] rg_rd_data1;
    logic [31:0] rg_rd_data2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_decode_unit #(
        .PC_W       (PC_W),
        .IMEM_WORDS (IMEM_WORDS),
        .RESET_PC   (0),
        .NREGS      (NREGS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_dest (rg_wrt_dest),
        .rg_wrt_data (rg_wrt_data),
        .pc_out      (pc_out),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .rg_rd_data1 (rg_rd_data1),
        .rg_rd_data2 (rg_rd_data2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: plain integer PC, word-indexed memory, array register file.
    int          m_pc    = 0;
    logic        m_valid = 1'b0;
    int          m_idpc  = 0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_rf  [32] = '{default: 32'h0};
    logic [31:0] m_mem [32] = '{default: 32'h0};

    function automatic logic [31:0] model_fetch(input int pc);
        int w;
        w = pc / 4;
        return (w < IMEM_WORDS) ? m_mem[w] : NOP;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'h0;
        if (rg_wrt_en && rg_wrt_dest == rs) return rg_wrt_data;
        return m_rf[rs];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc    <= 0;
            m_valid <= 1'b0;
            m_idpc  <= 0;
            m_instr <= NOP;
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'h0;
        end else begin
            if (redirect_en) begin
                m_pc    <= (int'(redirect_pc) / 4) * 4;
                m_valid <= 1'b0;
                m_idpc  <= 0;
                m_instr <= NOP;
            end else if (!stall) begin
                m_pc    <= (m_pc + 4) % 256;
                m_valid <= 1'b1;
                m_idpc  <= m_pc;
                m_instr <= model_fetch(m_pc);
            end
            if (rg_wrt_en && rg_wrt_dest != 5'd0) m_rf[rg_wrt_dest] <= rg_wrt_data;
        end
    end

    always @(posedge clk) begin
        if (imem_we && (int'(imem_waddr) / 4) < IMEM_WORDS) m_mem[int'(imem_waddr) / 4] <= imem_wdata;
    end

    always @(negedge clk) begin
        chk("pc_out",   32'(pc_out),   32'(m_pc));
        chk("id_valid", 32'(id_valid), 32'(m_valid));
        chk("id_pc",    32'(id_pc),    32'(m_idpc));
        chk("id_instr", id_instr,      m_instr);
        chk("rd_data1", rg_rd_data1,   model_read(m_instr[19:15]));
        chk("rd_data2", rg_rd_data2,   model_read(m_instr[24:20]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [32];

    initial begin
        prog[0] = 32'h0010_0093;
        prog[1] = 32'h0020_8113;
        prog[2] = 32'h0031_0193;
        prog[3] = 32'h0041_8213;
        for (int i = 4; i < 32; i++) prog[i] = {12'(i), 5'(i % 8), 3'b000, 5'(i), 7'h13};

        // Program load while held in reset, then one out-of-range write that must be dropped.
        for (int i = 0; i < 32; i++) begin
            imem_we = 1'b1; imem_waddr = 8'(i * 4); imem_wdata = prog[i];
            step();
        end
        imem_waddr = 8'd160; imem_wdata = 32'hBADD_0000;
        step();
        imem_we = 1'b0;
        chk("rst_pc",    32'(pc_out),   32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_instr", id_instr,      NOP);
        chk("rst_idpc",  32'(id_pc),    32'h0);

        // Sequential fetch.
        reset = 1'b1;
        step();
        chk("seq_pc4",    32'(pc_out), 32'h4);
        chk("seq_idpc0",  32'(id_pc),  32'h0);
        chk("seq_instr0", id_instr,    32'h0010_0093);
        step();
        chk("seq_pc8",    32'(pc_out), 32'h8);
        chk("seq_idpc4",  32'(id_pc),  32'h4);
        chk("seq_instr1", id_instr,    32'h0020_8113);

        // Bypass: write x2 while x2 is being read.
        rg_wrt_en = 1'b1; rg_wrt_dest = 5'd2; rg_wrt_data = 32'hDEAD_BEEF;
        #1;
        chk("bypass_rd2", rg_rd_data2, 32'hDEAD_BEEF);
        chk("bypass_rd1", rg_rd_data1, 32'h0);
        step();
        rg_wrt_en = 1'b0;
        chk("seq_pc12",   32'(pc_out), 32'hC);
        chk("seq_idpc8",  32'(id_pc),  32'h8);
        chk("x2_stored",  rg_rd_data1, 32'hDEAD_BEEF);

        // Stall hold for three cycles, then resume.
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_pc",    32'(pc_out), 32'hC);
            chk("stall_idpc",  32'(id_pc),  32'h8);
            chk("stall_instr", id_instr,    32'h0031_0193);
        end
        stall = 1'b0;
        step();
        chk("resume_pc",    32'(pc_out), 32'h10);
        chk("resume_instr", id_instr,    32'h0041_8213);

        // Redirect together with stall: redirect wins and flushes.
        redirect_en = 1'b1; redirect_pc = 8'h23; stall = 1'b1;
        step();
        redirect_en = 1'b0; stall = 1'b0;
        chk("redir_pc",    32'(pc_out),   32'h20);
        chk("redir_valid", 32'(id_valid), 32'h0);
        chk("redir_instr", id_instr,      NOP);
        chk("redir_idpc",  32'(id_pc),    32'h0);

        // Write to x0 during the bubble: never visible.
        rg_wrt_en = 1'b1; rg_wrt_dest = 5'd0; rg_wrt_data = 32'h1234_5678;
        #1;
        chk("x0_bypass", rg_rd_data1, 32'h0);
        step();
        rg_wrt_en = 1'b0;
        chk("word8_kept", id_instr,    32'h0080_0413);
        chk("x0_after",   rg_rd_data1, 32'h0);

        // Wrap-around and out-of-range fetch.
        redirect_en = 1'b1; redirect_pc = 8'hF8;
        step();
        redirect_en = 1'b0;
        step();
        chk("oor_pc",    32'(pc_out),   32'hFC);
        chk("oor_valid", 32'(id_valid), 32'h1);
        chk("oor_instr", id_instr,      NOP);
        step();
        chk("wrap_pc",    32'(pc_out), 32'h0);
        chk("wrap_idpc",  32'(id_pc),  32'hFC);
        chk("wrap_instr", id_instr,    NOP);
        step();
        chk("wrap_next", id_instr, 32'h0010_0093);
        step();

        // Asynchronous reset between edges, held with stall and redirect asserted.
        #2 reset = 1'b0;
        #1;
        chk("async_pc",    32'(pc_out),   32'h0);
        chk("async_valid", 32'(id_valid), 32'h0);
        chk("async_instr", id_instr,      NOP);
        stall = 1'b1; redirect_en = 1'b1; redirect_pc = 8'h40;
        step();
        step();
        chk("rst_override_pc", 32'(pc_out), 32'h0);
        stall = 1'b0; redirect_en = 1'b0;
        reset = 1'b1;
        step();
        chk("post_rst_pc",    32'(pc_out),   32'h4);
        chk("post_rst_valid", 32'(id_valid), 32'h1);
        chk("post_rst_instr", id_instr,      32'h0010_0093);
        step();
        chk("rf_cleared", rg_rd_data2, 32'h0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
